// File: rtl/dflop_pkg.sv
// Shared defaults, counter-width helper and output-buffer state encoding
// for the serial deserializer.
package dflop_pkg;

    localparam int DESER_WIDTH_DEF = 8;
    localparam bit MSB_FIRST_DEF   = 1'b1;

    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/dflop_deser_bit_counter.sv
// Modulo-WIDTH bit counter with enable and synchronous clear; flags the
// position of the final bit of a frame.
module deser_bit_counter
    import dflop_pkg::*;
#(
    parameter int WIDTH = DESER_WIDTH_DEF,
    localparam int CW   = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          last;

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = last;

endmodule

// File: rtl/dflop_deser.sv
// Serial-to-parallel deserializer with a single-entry ready/valid output
// buffer and a sticky overrun flag for words dropped during a stall.
//
// state     | meaning
// BUF_EMPTY | no unconsumed word, word_valid=0
// BUF_FULL  | word holds an unconsumed word, word_valid=1
module dflop_deser
    import dflop_pkg::*;
#(
    parameter int WIDTH     = DESER_WIDTH_DEF,
    parameter bit MSB_FIRST = MSB_FIRST_DEF,
    localparam int CW       = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    output logic [CW-1:0]    bit_cnt
);

    buf_state_e       state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] word_q;
    logic             overrun_q;
    logic             accept;
    logic             last_bit;
    logic             complete;

    // clr discards the bit presented with it, so it also blocks completion
    assign accept   = en && !clr;
    assign complete = accept && last_bit;

    deser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (accept),
        .clr_i  (clr),
        .cnt_o  (bit_cnt),
        .last_o (last_bit)
    );

    always_comb begin
        if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], d};
        end else begin
            shift_d = {d, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BUF_EMPTY;
            shift_q   <= '0;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (clr) begin
                shift_q   <= '0;
                overrun_q <= 1'b0;
            end else if (en) begin
                shift_q <= shift_d;
            end

            case (state_q)
                BUF_EMPTY: begin
                    if (complete) begin
                        word_q  <= shift_d;
                        state_q <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    // a consume on the completing edge frees the slot for the new word
                    if (complete) begin
                        if (word_ready) begin
                            word_q <= shift_d;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (word_ready) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    assign word       = word_q;
    assign word_valid = (state_q == BUF_FULL);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_dflop_deser.sv
// Directed bench for dflop_deser: MSB-first and LSB-first instances share
// one stimulus stream and are checked against hand-computed words.
module tb_dflop_deser;

    logic       clk;
    logic       rst_n;
    logic       d;
    logic       en;
    logic       clr;
    logic       word_ready;
    logic [7:0] word_m;
    logic [7:0] word_l;
    logic       valid_m;
    logic       valid_l;
    logic       ovr_m;
    logic       ovr_l;
    logic [2:0] cnt_m;
    logic [2:0] cnt_l;

    int ntests = 0;
    int nfail  = 0;

    dflop_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .clr(clr),
        .word(word_m), .word_valid(valid_m), .word_ready(word_ready),
        .overrun(ovr_m), .bit_cnt(cnt_m)
    );

    dflop_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .d(d), .en(en), .clr(clr),
        .word(word_l), .word_valid(valid_l), .word_ready(word_ready),
        .overrun(ovr_l), .bit_cnt(cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic       en;
        logic       clr;
        logic       rdy;
        logic [7:0] wm;
        logic [7:0] wl;
        logic       v;
        logic [2:0] cnt;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] wm, input logic [7:0] wl,
                           input logic v, input logic [2:0] cnt, input logic ovr);
        chk({tag, " word_m"},  32'(word_m),  32'(wm));
        chk({tag, " word_l"},  32'(word_l),  32'(wl));
        chk({tag, " valid_m"}, 32'(valid_m), 32'(v));
        chk({tag, " valid_l"}, 32'(valid_l), 32'(v));
        chk({tag, " cnt_m"},   32'(cnt_m),   32'(cnt));
        chk({tag, " cnt_l"},   32'(cnt_l),   32'(cnt));
        chk({tag, " ovr_m"},   32'(ovr_m),   32'(ovr));
        chk({tag, " ovr_l"},   32'(ovr_l),   32'(ovr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic ev, input logic cv, input logic rv);
        d = dv; en = ev; clr = cv; word_ready = rv;
    endtask

    // bits[7] is sent first; expected words are supplied by the caller
    task automatic add_frame(input logic [7:0] bits, input logic [7:0] pm, input logic [7:0] pl,
                             input logic [7:0] nm, input logic [7:0] nl);
        vec_t v;
        for (int k = 0; k < 8; k++) begin
            v.d = bits[7-k]; v.en = 1'b1; v.clr = 1'b0; v.rdy = 1'b1;
            v.v = (k == 7); v.cnt = 3'((k + 1) % 8); v.ovr = 1'b0;
            v.wm = (k == 7) ? nm : pm;
            v.wl = (k == 7) ? nl : pl;
            vecs.push_back(v);
        end
        v.d = 1'b1; v.en = 1'b0; v.clr = 1'b0; v.rdy = 1'b1;
        v.v = 1'b0; v.cnt = 3'd0; v.ovr = 1'b0; v.wm = nm; v.wl = nl;
        vecs.push_back(v);
    endtask

    task automatic send(input logic [7:0] bits, input logic rdy);
        for (int k = 0; k < 8; k++) begin
            drive(bits[7-k], 1'b1, 1'b0, rdy);
            step();
        end
    endtask

    initial begin
        logic [7:0] b;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        chk_all("reset", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();

        // consecutive frames, consumer always ready
        add_frame(8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5);
        add_frame(8'hC0, 8'hA5, 8'hA5, 8'hC0, 8'h03);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].d, vecs[i].en, vecs[i].clr, vecs[i].rdy);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].wm, vecs[i].wl, vecs[i].v, vecs[i].cnt, vecs[i].ovr);
        end

        // enable gaps of 3 cycles between bits of 3C
        b = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            drive(b[7-k], 1'b1, 1'b0, 1'b1);
            step();
            if (k < 7) begin
                for (int g = 0; g < 3; g++) begin
                    drive(~b[7-k], 1'b0, 1'b0, 1'b1);
                    step();
                    chk($sformatf("gap%0d_%0d cnt", k, g), 32'(cnt_m), 32'(k + 1));
                end
            end
        end
        chk_all("gap done", 8'h3C, 8'h3C, 1'b1, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // stall: second word dropped, overrun sticky until clr
        send(8'h11, 1'b0);
        chk_all("stall w1", 8'h11, 8'h88, 1'b1, 3'd0, 1'b0);
        send(8'h22, 1'b0);
        chk_all("stall w2", 8'h11, 8'h88, 1'b1, 3'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("stall drain", 8'h11, 8'h88, 1'b0, 3'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_all("stall clr", 8'h11, 8'h88, 1'b0, 3'd0, 1'b0);

        // consume and complete on the same edge
        send(8'h11, 1'b0);
        b = 8'h55;
        for (int k = 0; k < 7; k++) begin
            drive(b[7-k], 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_all("swap pre", 8'h11, 8'h88, 1'b1, 3'd7, 1'b0);
        drive(b[0], 1'b1, 1'b0, 1'b1);
        step();
        chk_all("swap", 8'h55, 8'hAA, 1'b1, 3'd0, 1'b0);

        // asynchronous reset mid-frame with a word buffered
        b = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            drive(b[k], 1'b1, 1'b0, 1'b0);
            step();
        end
        chk_all("pre rst", 8'h55, 8'hAA, 1'b1, 3'd5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async rst", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        send(8'hF0, 1'b0);
        chk_all("after rst", 8'hF0, 8'h0F, 1'b1, 3'd0, 1'b0);

        // clr mid-frame discards its bit but keeps the buffered word
        send(8'hE0, 1'b0);
        chk_all("ovr pre clr", 8'hF0, 8'h0F, 1'b1, 3'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("mid cnt", 32'(cnt_m), 32'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("mid clr", 8'hF0, 8'h0F, 1'b1, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_all("mid drain", 8'hF0, 8'h0F, 1'b0, 3'd0, 1'b0);
        send(8'h96, 1'b0);
        chk_all("post clr", 8'h96, 8'h69, 1'b1, 3'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dflop_deser.md
Name: dflop_deser

Overview:
Serial-to-parallel deserializer that consumes the bit stream produced by the enabled D flip-flop stage (registered data bit plus its enable). It assembles WIDTH accepted bits into a word and presents the word on a single-entry ready/valid output buffer. A sticky overrun flag reports words lost because the downstream consumer stalled.

Parameters:
WIDTH, 8, bits per word; legal range 2..32
MSB_FIRST, 1, 1 = first accepted bit lands in word[WIDTH-1]; 0 = first bit lands in word[0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
d  input  1  serial data bit (Q of upstream flop)
en  input  1  d is valid this cycle; bit accepted at the rising edge
clr  input  1  synchronous clear of partial frame and overrun flag
word  output  WIDTH  assembled word; stable while word_valid=1
word_valid  output  1  word holds an unconsumed word
word_ready  input  1  consumer accepts word at the edge where word_valid && word_ready
overrun  output  1  sticky: a completed word was dropped
bit_cnt  output  clog2(WIDTH)  bits accepted in the current partial frame

Behaviour:
- Reset (rst_n=0, asynchronous): shift register=0, bit_cnt=0, word=0, word_valid=0, overrun=0. Reset mid-frame discards the partial frame and any buffered word.
- Accept: at an edge with en=1 and clr=0, d shifts in and bit_cnt increments. MSB_FIRST=1 shifts left with d entering at bit 0. MSB_FIRST=0 shifts right with d entering at bit WIDTH-1.
- en=0: shift register and bit_cnt hold, so gaps of any length are allowed.
- Completion: an edge with en=1 and bit_cnt==WIDTH-1 completes the frame. At that same edge:
  - bit_cnt wraps to 0.
  - The full word (shift contents plus this d) is loaded into word, with word_valid=1.
  - Latency: word_valid rises at the edge that samples the last bit, i.e. it is visible 0 cycles after that edge.
- Output buffer FSM, two states:
  - EMPTY (word_valid=0) -> FULL on completion.
  - FULL -> EMPTY on word_valid && word_ready with no completion at the same edge.
  - FULL + completion + word_ready=1 at the same edge: the new word replaces the old one and the FSM stays FULL. No loss.
  - FULL + completion + word_ready=0: the new word is dropped, word keeps the old value, and overrun is set to 1.
  - word_ready while EMPTY has no effect.
- clr=1 at an edge: shift register=0, bit_cnt=0, overrun=0. The bit presented with en at that edge is discarded (clr wins). word and word_valid are unaffected, so a buffered word survives clr.
- clr has priority over completion. A completion cannot occur on a clr edge.
- overrun stays at 1 until clr or reset.
- The output word changes only on a completion load. It never changes while word_valid=1 and no load occurs.

Decomposition:
- Shared package dflop_pkg:
  - DESER_WIDTH_DEF=8
  - MSB_FIRST_DEF=1
  - localparam function for the counter width, clog2(WIDTH) with a minimum of 1
  - buffer state encoding: BUF_EMPTY=1'b0, BUF_FULL=1'b1
- One natural sub-module: deser_bit_counter, a modulo-WIDTH counter with enable and synchronous clear. Its outputs are the count and a last-bit flag (count==WIDTH-1). The shift register, output buffer and overrun logic stay in the top module.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, word_ready=1; send 1,0,1,0,0,1,0,1 with en=1 on consecutive edges -> at the 8th edge word=8'hA5, word_valid=1 for one cycle, bit_cnt=0, overrun=0.
2. MSB_FIRST=0; send the same bit sequence 1,0,1,0,0,1,0,1 -> word=8'hA5 (bit-reversed sequence is a palindrome check). Then send 1,1,0,0,0,0,0,0 -> word=8'h03.
3. en gaps: send 8'h3C MSB-first with en deasserted for 3 cycles between each bit -> word=8'h3C, and bit_cnt holds during every gap.
4. Stall and overrun: word_ready=0; send 8'h11 and then 8'h22 -> word stays 8'h11, word_valid=1, overrun=1. Raise word_ready -> word_valid=0 at the next edge. Pulse clr -> overrun=0.
5. Simultaneous consume and complete: hold word_ready=1 so the 8th bit of 8'h55 arrives while 8'h11 is buffered -> word=8'h55, word_valid stays 1, overrun=0.
6. Reset and clr mid-frame:
   - After 5 bits, assert rst_n=0 asynchronously between edges -> all outputs 0 immediately. Then a full 8'hF0 decodes correctly.
   - After 3 bits, pulse clr with en=1 -> bit_cnt=0, and the next 8 bits form the word.
